// File: rtl/mux21_4bit_arb.sv
// Two-input 4-bit stream merger: round-robin arbiter feeding a 2-entry tagged output FIFO.
// Build option: define MUX21_PRIO_EN for fixed A-over-B priority (no last-grant register).
module mux21_4bit_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic       A_valid,
  output logic       A_ready,
  input  logic [3:0] B,
  input  logic       B_valid,
  output logic       B_ready,
  output logic [3:0] X,
  output logic       S,
  output logic       X_valid,
  input  logic       X_ready
);

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        wr_entry;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ptr_q, rd_ptr_q;
  logic          full, empty;
  logic          grant_a, grant_b;
  logic          push, pop;

`ifdef MUX21_PRIO_EN
  // Fixed priority: A wins every tie.
  always_comb begin
    grant_a = A_valid;
    grant_b = B_valid && !A_valid;
  end
`else
  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_e;

  last_e last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_B;
    end else begin
      last_q <= last_d;
    end
  end

  // Last grant only moves when a word is actually accepted.
  always_comb begin
    last_d = last_q;
    if (push) begin
      last_d = grant_b ? LAST_B : LAST_A;
    end
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (A_valid && B_valid) begin
      grant_a = (last_q == LAST_B);
      grant_b = (last_q == LAST_A);
    end else begin
      grant_a = A_valid;
      grant_b = B_valid;
    end
  end
`endif

  // No push-through when full, even if the head is popped this cycle.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    A_ready  = grant_a && !full;
    B_ready  = grant_b && !full;
    push     = (grant_a || grant_b) && !full;
    pop      = !empty && X_ready;
    wr_entry = '{src: grant_b, data: (grant_b ? B : A)};
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Head entry drives the consumer side directly from storage.
  always_comb begin
    X       = mem_q[rd_ptr_q].data;
    S       = mem_q[rd_ptr_q].src;
    X_valid = !empty;
  end

endmodule
